// File: rtl/lvds_rx_buf_arbiter_pkg.sv
// Shared definitions for the LVDS receive-buffer arbiter: lane FSM encodings,
// state-byte bit positions and the lane count.
package lvds_rx_buf_arbiter_pkg;

    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {
        LANE_IDLE = 2'd0,
        LANE_RECV = 2'd1,
        LANE_DONE = 2'd2
    } lane_state_t;

    localparam int ST_DONE    = 0;
    localparam int ST_BUSY    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_SOFERR  = 3;
    localparam int ST_CNT_LSB = 4;

endpackage

// File: rtl/lvds_rx_lane_ctrl.sv
// Per-lane frame controller: frame FSM, buffer write pointer, error flags and
// the completed-frame counter that together form the lane state byte.
module lvds_rx_lane_ctrl
    import lvds_rx_buf_arbiter_pkg::*;
#(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hs,
    input  logic              sof,
    input  logic              eof,
    input  logic              clr,
    output logic              active,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        state_byte
);

    localparam logic [ADDR_W:0] PTR_ONE = 1;
    localparam logic [3:0]      CNT_ONE = 4'd1;

    lane_state_t     state, state_n;
    logic [ADDR_W:0] wptr, wptr_n;
    logic            ovf, ovf_n;
    logic            sof_err, sof_err_n;
    logic [3:0]      frame_cnt, frame_cnt_n;
    logic            full;

    // The pointer is one bit wider than the address so it can sit at 2^N when full.
    assign full    = wptr[ADDR_W];
    assign active  = (state != LANE_DONE);
    assign wr_addr = wptr[ADDR_W-1:0];
    assign wr_en   = ((state == LANE_IDLE) && sof) || ((state == LANE_RECV) && !full);

    always_comb begin
        state_n     = state;
        wptr_n      = wptr;
        ovf_n       = ovf;
        sof_err_n   = sof_err;
        frame_cnt_n = frame_cnt;
        if (clr) begin
            state_n   = LANE_IDLE;
            wptr_n    = '0;
            ovf_n     = 1'b0;
            sof_err_n = 1'b0;
        end else if (hs) begin
            case (state)
                LANE_IDLE: begin
                    if (sof) begin
                        wptr_n = PTR_ONE;
                        if (eof) begin
                            state_n     = LANE_DONE;
                            frame_cnt_n = frame_cnt + CNT_ONE;
                        end else begin
                            state_n = LANE_RECV;
                        end
                    end else begin
                        sof_err_n = 1'b1;
                    end
                end
                LANE_RECV: begin
                    if (full) ovf_n = 1'b1;
                    else      wptr_n = wptr + PTR_ONE;
                    if (sof) sof_err_n = 1'b1;
                    if (eof) begin
                        state_n     = LANE_DONE;
                        frame_cnt_n = frame_cnt + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LANE_IDLE;
            wptr      <= '0;
            ovf       <= 1'b0;
            sof_err   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_n;
            wptr      <= wptr_n;
            ovf       <= ovf_n;
            sof_err   <= sof_err_n;
            frame_cnt <= frame_cnt_n;
        end
    end

    always_comb begin
        state_byte                       = '0;
        state_byte[ST_DONE]              = (state == LANE_DONE);
        state_byte[ST_BUSY]              = (state == LANE_RECV);
        state_byte[ST_OVF]               = ovf;
        state_byte[ST_SOFERR]            = sof_err;
        state_byte[ST_CNT_LSB +: 4]      = frame_cnt;
    end

endmodule

// File: rtl/lvds_rx_buf_arbiter.sv
// Round-robin arbiter sharing one registered buffer write port among four LVDS
// receive lanes, plus the per-lane state bytes read by the AHB bridge.
module lvds_rx_buf_arbiter
    import lvds_rx_buf_arbiter_pkg::*;
#(
    parameter int LVDS_BUF_ADDR_SIZE = 9
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic [3:0]                    RX_VALID,
    input  logic [127:0]                  RX_DATA,
    input  logic [3:0]                    RX_SOF,
    input  logic [3:0]                    RX_EOF,
    output logic [3:0]                    RX_READY,
    output logic [3:0]                    BUF_WE,
    output logic [LVDS_BUF_ADDR_SIZE-1:0] BUF_WADDR,
    output logic [31:0]                   BUF_WDATA,
    input  logic                          RX_STATE_CLEAR,
    input  logic                          LVDS_EU1,
    input  logic                          LVDS_EU2,
    input  logic                          LVDS_EU3,
    input  logic                          LVDS_EU4,
    output logic [7:0]                    LVDS_EU1_STATE,
    output logic [7:0]                    LVDS_EU2_STATE,
    output logic [7:0]                    LVDS_EU3_STATE,
    output logic [7:0]                    LVDS_EU4_STATE
);

    logic [NUM_LANES-1:0]          clr, active, wr_en, req, grant;
    logic [LVDS_BUF_ADDR_SIZE-1:0] lane_addr [NUM_LANES];
    logic [31:0]                   lane_word [NUM_LANES];
    logic [7:0]                    lane_state [NUM_LANES];
    logic [1:0]                    rr_ptr, grant_idx;
    logic                          grant_vld;

    // Reset also masks requests so RX_READY reads 0 while HRESETn is low.
    assign clr = {4{RX_STATE_CLEAR}} & {LVDS_EU4, LVDS_EU3, LVDS_EU2, LVDS_EU1};
    assign req = RX_VALID & active & ~clr & {4{HRESETn}};

    always_comb begin
        grant     = '0;
        grant_idx = rr_ptr;
        grant_vld = 1'b0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (!grant_vld && req[rr_ptr + 2'(k)]) begin
                grant_vld = 1'b1;
                grant_idx = rr_ptr + 2'(k);
            end
        end
        if (grant_vld) grant[grant_idx] = 1'b1;
    end

    assign RX_READY = grant;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_word[i] = RX_DATA[32*i +: 32];

        lvds_rx_lane_ctrl #(
            .ADDR_W (LVDS_BUF_ADDR_SIZE)
        ) u_lane (
            .clk        (HCLK),
            .rst_n      (HRESETn),
            .hs         (RX_VALID[i] & grant[i]),
            .sof        (RX_SOF[i]),
            .eof        (RX_EOF[i]),
            .clr        (clr[i]),
            .active     (active[i]),
            .wr_en      (wr_en[i]),
            .wr_addr    (lane_addr[i]),
            .state_byte (lane_state[i])
        );
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            BUF_WE    <= '0;
            BUF_WADDR <= '0;
            BUF_WDATA <= '0;
            rr_ptr    <= '0;
        end else begin
            BUF_WE <= grant & wr_en;
            if (grant_vld) begin
                rr_ptr    <= grant_idx + 2'd1;
                BUF_WADDR <= lane_addr[grant_idx];
                BUF_WDATA <= lane_word[grant_idx];
            end
        end
    end

    assign LVDS_EU1_STATE = lane_state[0];
    assign LVDS_EU2_STATE = lane_state[1];
    assign LVDS_EU3_STATE = lane_state[2];
    assign LVDS_EU4_STATE = lane_state[3];

endmodule

// File: tb/tb_lvds_rx_buf_arbiter.sv
// Self-checking bench for lvds_rx_buf_arbiter: directed scenarios plus a random
// phase, all compared against a lane-level behavioural model.
module tb_lvds_rx_buf_arbiter;

    localparam int DEPTH      = 512;
    localparam int MODE_IDLE  = 0;
    localparam int MODE_RECV  = 1;
    localparam int MODE_DONE  = 2;

    logic         HCLK;
    logic         HRESETn;
    logic [3:0]   RX_VALID, RX_SOF, RX_EOF;
    logic [127:0] RX_DATA;
    logic [3:0]   RX_READY, BUF_WE;
    logic [8:0]   BUF_WADDR;
    logic [31:0]  BUF_WDATA;
    logic         RX_STATE_CLEAR;
    logic [3:0]   eu_sel;
    logic [7:0]   st1, st2, st3, st4;

    int total = 0;
    int bad   = 0;

    int   m_mode   [4];
    int   m_words  [4];
    int   m_frames [4];
    bit   m_ovf    [4];
    bit   m_soferr [4];
    int   m_rr;
    logic [3:0]  exp_we;
    int          exp_addr;
    logic [31:0] exp_data;

    lvds_rx_buf_arbiter #(.LVDS_BUF_ADDR_SIZE(9)) dut (
        .HCLK           (HCLK),
        .HRESETn        (HRESETn),
        .RX_VALID       (RX_VALID),
        .RX_DATA        (RX_DATA),
        .RX_SOF         (RX_SOF),
        .RX_EOF         (RX_EOF),
        .RX_READY       (RX_READY),
        .BUF_WE         (BUF_WE),
        .BUF_WADDR      (BUF_WADDR),
        .BUF_WDATA      (BUF_WDATA),
        .RX_STATE_CLEAR (RX_STATE_CLEAR),
        .LVDS_EU1       (eu_sel[0]),
        .LVDS_EU2       (eu_sel[1]),
        .LVDS_EU3       (eu_sel[2]),
        .LVDS_EU4       (eu_sel[3]),
        .LVDS_EU1_STATE (st1),
        .LVDS_EU2_STATE (st2),
        .LVDS_EU3_STATE (st3),
        .LVDS_EU4_STATE (st4)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [127:0] randWords();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [7:0] expState(input int l);
        logic [7:0] s;
        s      = '0;
        s[7:4] = 4'(m_frames[l] % 16);
        s[3]   = m_soferr[l];
        s[2]   = m_ovf[l];
        s[1]   = (m_mode[l] == MODE_RECV);
        s[0]   = (m_mode[l] == MODE_DONE);
        return s;
    endfunction

    task automatic resetModel();
        for (int l = 0; l < 4; l++) begin
            m_mode[l]   = MODE_IDLE;
            m_words[l]  = 0;
            m_frames[l] = 0;
            m_ovf[l]    = 1'b0;
            m_soferr[l] = 1'b0;
        end
        m_rr     = 0;
        exp_we   = '0;
        exp_addr = 0;
        exp_data = '0;
    endtask

    task automatic checkStates();
        logic [7:0] obs [4];
        obs[0] = st1; obs[1] = st2; obs[2] = st3; obs[3] = st4;
        for (int l = 0; l < 4; l++)
            checkOutput($sformatf("state_eu%0d", l + 1), 32'(obs[l]), 32'(expState(l)));
    endtask

    // Lane-level model of one clock edge: clears, then the accepted word.
    task automatic modelEdge(input int gl, input logic [3:0] clrv);
        logic [31:0] word;
        exp_we = '0;
        for (int l = 0; l < 4; l++) begin
            if (clrv[l]) begin
                m_mode[l]   = MODE_IDLE;
                m_words[l]  = 0;
                m_ovf[l]    = 1'b0;
                m_soferr[l] = 1'b0;
            end
        end
        if (gl >= 0) begin
            m_rr = (gl + 1) % 4;
            word = RX_DATA[32*gl +: 32];
            if (m_mode[gl] == MODE_IDLE) begin
                if (RX_SOF[gl]) begin
                    exp_we      = 4'(1 << gl);
                    exp_addr    = 0;
                    exp_data    = word;
                    m_words[gl] = 1;
                    if (RX_EOF[gl]) begin
                        m_mode[gl] = MODE_DONE;
                        m_frames[gl]++;
                    end else begin
                        m_mode[gl] = MODE_RECV;
                    end
                end else begin
                    m_soferr[gl] = 1'b1;
                end
            end else begin
                if (m_words[gl] < DEPTH) begin
                    exp_we   = 4'(1 << gl);
                    exp_addr = m_words[gl];
                    exp_data = word;
                    m_words[gl]++;
                end else begin
                    m_ovf[gl] = 1'b1;
                end
                if (RX_SOF[gl]) m_soferr[gl] = 1'b1;
                if (RX_EOF[gl]) begin
                    m_mode[gl] = MODE_DONE;
                    m_frames[gl]++;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [3:0] v, input logic [3:0] s, input logic [3:0] e,
                                 input logic clr, input logic [3:0] sel, input logic [127:0] d);
        RX_VALID       = v;
        RX_SOF         = s;
        RX_EOF         = e;
        RX_STATE_CLEAR = clr;
        eu_sel         = sel;
        RX_DATA        = d;
    endtask

    // Called at posedge+1 with inputs applied; returns at the next posedge+1.
    task automatic runCycle();
        int         gl;
        int         l;
        logic [3:0] clrv;
        logic [3:0] gexp;
        #1;
        clrv = RX_STATE_CLEAR ? eu_sel : 4'b0000;
        gl   = -1;
        for (int k = 0; k < 4; k++) begin
            l = (m_rr + k) % 4;
            if (gl < 0 && RX_VALID[l] && m_mode[l] != MODE_DONE && !clrv[l]) gl = l;
        end
        gexp = (gl < 0) ? 4'b0000 : 4'(1 << gl);
        checkOutput("rx_ready", 32'(RX_READY), 32'(gexp));
        @(posedge HCLK);
        modelEdge(gl, clrv);
        #1;
        checkOutput("buf_we", 32'(BUF_WE), 32'(exp_we));
        if (exp_we != 4'b0000) begin
            checkOutput("buf_waddr", 32'(BUF_WADDR), 32'(exp_addr));
            checkOutput("buf_wdata", BUF_WDATA, exp_data);
        end
        checkStates();
    endtask

    task automatic clearLanes(input logic [3:0] sel, input logic [3:0] v);
        for (int c = 0; c < 2; c++) begin
            applyStimulus(v, 4'b0, 4'b0, 1'b1, sel, randWords());
            runCycle();
        end
    endtask

    initial begin
        logic [127:0] d;
        logic         rclr;

        resetModel();
        HRESETn = 1'b0;
        applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 4'b0, '0);
        #12;
        checkOutput("reset_rx_ready", 32'(RX_READY), 32'h0);
        checkOutput("reset_buf_we", 32'(BUF_WE), 32'h0);
        checkOutput("reset_buf_waddr", 32'(BUF_WADDR), 32'h0);
        checkOutput("reset_buf_wdata", BUF_WDATA, 32'h0);
        checkStates();
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        $display("[TB] single 4-word frame on EU2");
        for (int i = 0; i < 4; i++) begin
            d         = randWords();
            d[63:32]  = 32'hA0 + 32'(i);
            applyStimulus(4'b0010, (i == 0) ? 4'b0010 : 4'b0, (i == 3) ? 4'b0010 : 4'b0, 1'b0, 4'b0, d);
            runCycle();
            checkOutput("eu2_waddr", 32'(BUF_WADDR), 32'(i));
            checkOutput("eu2_wdata", BUF_WDATA, 32'hA0 + 32'(i));
        end
        checkOutput("eu2_state_done", 32'(st2), 32'h11);
        applyStimulus(4'b0010, 4'b0010, 4'b0, 1'b0, 4'b0, randWords());
        runCycle();
        checkOutput("eu2_backpressure", 32'(RX_READY[1]), 32'h0);
        clearLanes(4'b0010, 4'b0);

        $display("[TB] all lanes continuously valid");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(4'b1111, (i < 4) ? 4'b1111 : 4'b0, 4'b0, 1'b0, 4'b0, randWords());
            runCycle();
        end
        clearLanes(4'b1111, 4'b0);

        $display("[TB] overflow on EU1");
        for (int i = 0; i < 516; i++) begin
            applyStimulus(4'b0001, (i == 0) ? 4'b0001 : 4'b0, (i == 515) ? 4'b0001 : 4'b0,
                          1'b0, 4'b0, randWords());
            runCycle();
        end
        checkOutput("eu1_state_ovf", 32'(st1), 32'h15);
        clearLanes(4'b0001, 4'b0);

        $display("[TB] missing SOF on EU3");
        applyStimulus(4'b0100, 4'b0, 4'b0, 1'b0, 4'b0, randWords());
        runCycle();
        checkOutput("eu3_state_soferr", 32'(st3), 32'h08);
        clearLanes(4'b0100, 4'b0);
        checkOutput("eu3_state_cleared", 32'(st3), 32'h00);

        $display("[TB] clear EU4 mid-frame");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'b1000, (i == 0) ? 4'b1000 : 4'b0, 4'b0, 1'b0, 4'b0, randWords());
            runCycle();
        end
        checkOutput("eu4_state_busy", 32'(st4), 32'h02);
        clearLanes(4'b1000, 4'b1000);
        checkOutput("eu4_state_aborted", 32'(st4), 32'h00);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1000, (i == 0) ? 4'b1000 : 4'b0, (i == 2) ? 4'b1000 : 4'b0,
                          1'b0, 4'b0, randWords());
            runCycle();
            checkOutput("eu4_restart_addr", 32'(BUF_WADDR), 32'(i));
        end
        checkOutput("eu4_state_frame", 32'(st4), 32'h11);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            rclr = ($urandom_range(0, 7) == 0);
            applyStimulus(4'($urandom()), ($urandom_range(0, 3) == 0) ? 4'($urandom()) : 4'b0,
                          ($urandom_range(0, 5) == 0) ? 4'($urandom()) : 4'b0,
                          rclr, 4'($urandom()), randWords());
            runCycle();
        end

        $display("[TB] asynchronous reset mid-frame");
        clearLanes(4'b1111, 4'b0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b1111, (i < 4) ? 4'b1111 : 4'b0, 4'b0, 1'b0, 4'b0, randWords());
            runCycle();
        end
        HRESETn = 1'b0;
        #1;
        resetModel();
        checkOutput("async_rx_ready", 32'(RX_READY), 32'h0);
        checkOutput("async_buf_we", 32'(BUF_WE), 32'h0);
        checkOutput("async_buf_waddr", 32'(BUF_WADDR), 32'h0);
        checkOutput("async_buf_wdata", BUF_WDATA, 32'h0);
        checkStates();
        applyStimulus(4'b0, 4'b0, 4'b0, 1'b0, 4'b0, '0);
        #14;
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        $display("[TB] FRAME_CNT wrap on EU1");
        for (int f = 0; f < 15; f++) begin
            applyStimulus(4'b0001, 4'b0001, 4'b0001, 1'b0, 4'b0, randWords());
            runCycle();
            clearLanes(4'b0001, 4'b0);
        end
        checkOutput("eu1_cnt15", 32'(st1), 32'hF0);
        applyStimulus(4'b0001, 4'b0001, 4'b0001, 1'b0, 4'b0, randWords());
        runCycle();
        checkOutput("eu1_cnt_wrap", 32'(st1), 32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
